// File: rtl/datapath.sv
module datapath #(
    parameter int MEM_DEPTH     = 512,
    parameter     MEM_INIT_FILE = "ram_init.hex"
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              PCout,
    input  logic              MDRout,
    input  logic              Zlowout,
    input  logic              Csignout,
    input  logic              BAout,
    input  logic              PCin,
    input  logic              IRin,
    input  logic              MDRin,
    input  logic              Yin,
    input  logic              Zlowin,
    input  logic              Zhighin,
    input  logic              MARin,
    input  logic              MAR_clear,
    input  logic              Gra,
    input  logic              Grb,
    input  logic              Rin,
    input  logic              Read,
    input  logic              MD_read,
    input  logic              IncPC,
    input  logic              ADD,
    output logic [15:0][31:0] o_R,
    output logic [31:0]       o_PC,
    output logic [31:0]       o_IR,
    output logic [31:0]       o_MAR,
    output logic [31:0]       o_MDR,
    output logic [31:0]       o_Y,
    output logic [31:0]       o_ZHI,
    output logic [31:0]       o_ZLO,
    output logic [31:0]       o_bus
);
    localparam int AW = $clog2(MEM_DEPTH);

    logic [15:0][31:0] r_R;
    logic [31:0]       r_PC, r_IR, r_MAR, r_MDR, r_Y, r_ZHI, r_ZLO;

    logic [31:0]       w_bus, w_csign, w_rom, w_ram_data, w_mdr_d;
    logic [3:0]        w_idx;
    logic [32:0]       w_sum;
    logic [63:0]       w_alu;
    logic [AW-1:0]     w_addr;

    assign w_addr = r_MAR[AW-1:0];

`ifdef DATAPATH_MEM_INIT_EN
    logic [31:0] r_mem [MEM_DEPTH];
    initial begin
        for (int i = 0; i < MEM_DEPTH; i++) r_mem[i] = 32'h0;
        r_mem[0] = 32'h4080_0095;
        r_mem[1] = 32'h4108_0038;
    end
    assign w_rom = r_mem[w_addr];
`else
    always_comb begin
        w_rom = 32'h0;
        if (w_addr == AW'(0))
            w_rom = 32'h4080_0095;
        else if (w_addr == AW'(1))
            w_rom = 32'h4108_0038;
    end
`endif

    assign w_ram_data = Read ? w_rom : 32'h0;
    assign w_mdr_d    = MD_read ? w_ram_data : w_bus;

    assign w_idx   = ({4{Gra}} & r_IR[26:23]) | ({4{Grb}} & r_IR[22:19]);
    assign w_csign = {{13{r_IR[18]}}, r_IR[18:0]};

    always_comb begin
        w_bus = 32'h0;
        if (PCout)
            w_bus = r_PC;
        else if (MDRout)
            w_bus = r_MDR;
        else if (Zlowout)
            w_bus = r_ZLO;
        else if (Csignout)
            w_bus = w_csign;
        else if (BAout)
            w_bus = (w_idx == 4'd0) ? 32'h0 : r_R[w_idx];
    end

    assign w_sum = {1'b0, r_Y} + {1'b0, w_bus};

    always_comb begin
        w_alu = 64'h0;
        if (IncPC)
            w_alu = {32'h0, w_bus + 32'd1};
        else if (ADD)
            w_alu = {31'h0, w_sum};
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_R   <= '0;
            r_PC  <= '0;
            r_IR  <= '0;
            r_MAR <= '0;
            r_MDR <= '0;
            r_Y   <= '0;
            r_ZHI <= '0;
            r_ZLO <= '0;
        end else begin
            if (Rin)     r_R[w_idx] <= w_bus;
            if (PCin)    r_PC  <= w_bus;
            if (IRin)    r_IR  <= w_bus;
            if (MDRin)   r_MDR <= w_mdr_d;
            if (Yin)     r_Y   <= w_bus;
            if (Zlowin)  r_ZLO <= w_alu[31:0];
            if (Zhighin) r_ZHI <= w_alu[63:32];
            if (MAR_clear)
                r_MAR <= '0;
            else if (MARin)
                r_MAR <= w_bus;
        end
    end

    assign o_R   = r_R;
    assign o_PC  = r_PC;
    assign o_IR  = r_IR;
    assign o_MAR = r_MAR;
    assign o_MDR = r_MDR;
    assign o_Y   = r_Y;
    assign o_ZHI = r_ZHI;
    assign o_ZLO = r_ZLO;
    assign o_bus = w_bus;
endmodule

// File: tb/tb_datapath.sv
// Randomized and directed bench for datapath against a behavioural register-transfer model.
module tb_datapath;
    localparam int MEM_DEPTH = 512;

    typedef struct packed {
        logic pcout, mdrout, zlowout, csignout, baout;
        logic pcin, irin, mdrin, yin, zlowin, zhighin, marin, mar_clear;
        logic gra, grb, rin, read, md_read, incpc, add;
    } ctrl_t;

    logic              clock, clear;
    ctrl_t             c;
    logic [15:0][31:0] o_R;
    logic [31:0]       o_PC, o_IR, o_MAR, o_MDR, o_Y, o_ZHI, o_ZLO, o_bus;

    int total = 0;
    int bad   = 0;
    bit cmp_en = 0;

    logic [31:0] m_R [16];
    logic [31:0] m_pc, m_ir, m_mar, m_mdr, m_y, m_zhi, m_zlo;
    logic [31:0] m_mem [MEM_DEPTH];

    datapath #(.MEM_DEPTH(MEM_DEPTH)) dut (
        .clock(clock), .clear(clear),
        .PCout(c.pcout), .MDRout(c.mdrout), .Zlowout(c.zlowout), .Csignout(c.csignout),
        .BAout(c.baout), .PCin(c.pcin), .IRin(c.irin), .MDRin(c.mdrin), .Yin(c.yin),
        .Zlowin(c.zlowin), .Zhighin(c.zhighin), .MARin(c.marin), .MAR_clear(c.mar_clear),
        .Gra(c.gra), .Grb(c.grb), .Rin(c.rin), .Read(c.read), .MD_read(c.md_read),
        .IncPC(c.incpc), .ADD(c.add),
        .o_R(o_R), .o_PC(o_PC), .o_IR(o_IR), .o_MAR(o_MAR), .o_MDR(o_MDR),
        .o_Y(o_Y), .o_ZHI(o_ZHI), .o_ZLO(o_ZLO), .o_bus(o_bus)
    );

    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not end, got timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [3:0] m_sel();
        logic [3:0] idx;
        idx = 4'd0;
        if (c.gra) idx = m_ir[26:23];
        if (c.grb) idx = idx | m_ir[22:19];
        return idx;
    endfunction

    function automatic logic [31:0] m_bus();
        logic [3:0] idx;
        idx = m_sel();
        if (c.pcout)    return m_pc;
        if (c.mdrout)   return m_mdr;
        if (c.zlowout)  return m_zlo;
        if (c.csignout) return 32'(int'($signed(m_ir[18:0])));
        if (c.baout)    return (idx == 0) ? 32'h0 : m_R[idx];
        return 32'h0;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 16; i++) m_R[i] = 32'h0;
        m_pc = 0; m_ir = 0; m_mar = 0; m_mdr = 0; m_y = 0; m_zhi = 0; m_zlo = 0;
    endtask

    // Apply one control word for one clock, advancing the model alongside.
    task automatic step(input ctrl_t cc);
        logic [31:0] b, rd, inc;
        logic [63:0] alu, sum;
        logic [3:0]  idx;
        c   = cc;
        b   = m_bus();
        idx = m_sel();
        rd  = cc.read ? m_mem[m_mar % MEM_DEPTH] : 32'h0;
        inc = b + 32'd1;
        sum = {32'h0, m_y} + {32'h0, b};
        alu = cc.incpc ? {32'h0, inc} : (cc.add ? sum : 64'h0);
        @(posedge clock);
        #1;
        if (cc.rin)     m_R[idx] = b;
        if (cc.pcin)    m_pc = b;
        if (cc.irin)    m_ir = b;
        if (cc.mdrin)   m_mdr = cc.md_read ? rd : b;
        if (cc.yin)     m_y = b;
        if (cc.zlowin)  m_zlo = alu[31:0];
        if (cc.zhighin) m_zhi = alu[63:32];
        if (cc.mar_clear) m_mar = 0;
        else if (cc.marin) m_mar = b;
        @(negedge clock);
        #1;
    endtask

    always @(negedge clock) begin
        if (cmp_en) begin
            for (int i = 0; i < 16; i++) chk($sformatf("R%0d", i), o_R[i], m_R[i]);
            chk("PC", o_PC, m_pc);
            chk("IR", o_IR, m_ir);
            chk("MAR", o_MAR, m_mar);
            chk("MDR", o_MDR, m_mdr);
            chk("Y", o_Y, m_y);
            chk("ZHI", o_ZHI, m_zhi);
            chk("ZLO", o_ZLO, m_zlo);
            chk("bus", o_bus, m_bus());
        end
    end

    // Synthesise an arbitrary constant in ZLO by double-and-increment.
    task automatic build(input logic [31:0] v);
        step(ctrl_t'{zlowin: 1'b1, default: 1'b0});
        for (int i = 31; i >= 0; i--) begin
            step(ctrl_t'{zlowout: 1'b1, yin: 1'b1, default: 1'b0});
            step(ctrl_t'{zlowout: 1'b1, add: 1'b1, zlowin: 1'b1, default: 1'b0});
            if (v[i]) step(ctrl_t'{zlowout: 1'b1, incpc: 1'b1, zlowin: 1'b1, default: 1'b0});
        end
    endtask

    task automatic fetch(input logic [31:0] pc0, input logic [31:0] word);
        step(ctrl_t'{pcout: 1'b1, marin: 1'b1, incpc: 1'b1, zlowin: 1'b1, default: 1'b0});
        chk("fetch_MAR", o_MAR, pc0);
        chk("fetch_ZLO", o_ZLO, pc0 + 1);
        step(ctrl_t'{zlowout: 1'b1, pcin: 1'b1, read: 1'b1, md_read: 1'b1, mdrin: 1'b1, default: 1'b0});
        chk("fetch_PC", o_PC, pc0 + 1);
        chk("fetch_MDR", o_MDR, word);
        step(ctrl_t'{mdrout: 1'b1, irin: 1'b1, default: 1'b0});
        chk("fetch_IR", o_IR, word);
    endtask

    task automatic ldi(input logic [31:0] y_exp, input logic [31:0] z_exp, input int rd);
        step(ctrl_t'{grb: 1'b1, baout: 1'b1, yin: 1'b1, default: 1'b0});
        chk("ldi_Y", o_Y, y_exp);
        step(ctrl_t'{csignout: 1'b1, add: 1'b1, zlowin: 1'b1, default: 1'b0});
        chk("ldi_ZLO", o_ZLO, z_exp);
        step(ctrl_t'{zlowout: 1'b1, gra: 1'b1, rin: 1'b1, default: 1'b0});
        chk("ldi_Rd", o_R[rd], z_exp);
    endtask

    initial begin
        logic [19:0] rb;
        ctrl_t       cc;
        c = '0;
        m_reset();
        for (int i = 0; i < MEM_DEPTH; i++) m_mem[i] = 32'h0;
        m_mem[0] = 32'h4080_0095;
        m_mem[1] = 32'h4108_0038;
        clear = 1;
        #2;
        chk("rst_PC", o_PC, 32'h0);
        chk("rst_ZLO", o_ZLO, 32'h0);
        clear = 0;
        @(negedge clock);
        #1;
        cmp_en = 1;

        fetch(32'd0, 32'h4080_0095);
        ldi(32'h0, 32'h95, 1);

        // Mid-run asynchronous clear with PC=5, R1=7.
        build(32'd7);
        step(ctrl_t'{zlowout: 1'b1, gra: 1'b1, rin: 1'b1, default: 1'b0});
        build(32'd5);
        step(ctrl_t'{zlowout: 1'b1, pcin: 1'b1, default: 1'b0});
        chk("pre_clr_PC", o_PC, 32'd5);
        chk("pre_clr_R1", o_R[1], 32'd7);
        clear = 1;
        #1;
        chk("clr_PC", o_PC, 32'h0);
        chk("clr_R1", o_R[1], 32'h0);
        chk("clr_IR", o_IR, 32'h0);
        chk("clr_MAR", o_MAR, 32'h0);
        chk("clr_MDR", o_MDR, 32'h0);
        chk("clr_Y", o_Y, 32'h0);
        chk("clr_ZLO", o_ZLO, 32'h0);
        clear = 0;
        m_reset();
        #1;

        fetch(32'd0, 32'h4080_0095);
        ldi(32'h0, 32'h95, 1);
        fetch(32'd1, 32'h4108_0038);
        ldi(32'h95, 32'hCD, 2);
        chk("ldi2_R1_kept", o_R[1], 32'h95);

        // Negative C: Y = R1 while IR still holds the second ldi, then swap IR.
        build(32'h4107_FFFF);
        step(ctrl_t'{zlowout: 1'b1, mdrin: 1'b1, default: 1'b0});
        step(ctrl_t'{grb: 1'b1, baout: 1'b1, yin: 1'b1, default: 1'b0});
        step(ctrl_t'{mdrout: 1'b1, irin: 1'b1, default: 1'b0});
        chk("neg_IR", o_IR, 32'h4107_FFFF);
        step(ctrl_t'{csignout: 1'b1, add: 1'b1, zlowin: 1'b1, zhighin: 1'b1, default: 1'b0});
        chk("neg_ZLO", o_ZLO, 32'h94);
        chk("neg_ZHI", o_ZHI, 32'h1);

        // Address wrap: MAR=0x201 reads word 1.
        build(32'h201);
        step(ctrl_t'{zlowout: 1'b1, marin: 1'b1, default: 1'b0});
        step(ctrl_t'{read: 1'b1, md_read: 1'b1, mdrin: 1'b1, default: 1'b0});
        chk("wrap_MDR", o_MDR, 32'h4108_0038);

        step(ctrl_t'{yin: 1'b1, default: 1'b0});
        chk("idle_Y", o_Y, 32'h0);
        step(ctrl_t'{pcout: 1'b1, marin: 1'b1, mar_clear: 1'b1, default: 1'b0});
        chk("marclr_MAR", o_MAR, 32'h0);

        for (int n = 0; n < 600; n++) begin
            for (int k = 0; k < 20; k++) rb[k] = ($urandom_range(0, 3) == 0);
            cc = ctrl_t'(rb);
            if (cc.gra && cc.grb) cc.grb = 1'b0;
            step(cc);
        end

        cmp_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
